// File: rtl/cnt_pkg.sv
// Shared display-mode encodings for the LED counter blocks.
// Kept in a package so other prescaler users can decode the same modes.
package cnt_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_BINARY = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

endpackage

// File: rtl/multi_cnt_led_if.sv
// Control/status bundle of multi_cnt_led: enable and mode in, tick and LEDs out.
// master = controller side, slave = the LED block.
interface multi_cnt_led_if #(
    parameter int CH_NUM = 4
) ();
    import cnt_pkg::*;

    logic              en;
    mode_e             mode;
    logic              tick;
    logic [CH_NUM-1:0] led;

    modport master (output en, output mode, input tick, input led);
    modport slave  (input en, input mode, output tick, output led);

endinterface

// File: rtl/cnt_tick.sv
// Free-running prescaler 0..CNT_VAL-1 with enable and synchronous clear.
// wrap is combinational (last count while enabled); tick is its registered copy.
module cnt_tick #(
    parameter int               CNT_W   = 25,
    parameter logic [CNT_W-1:0] CNT_VAL = 25'd25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic wrap,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_VAL - 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        wrap   = en && (cnt_q == LAST);
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        // clear wins over a wrap in the same cycle, so that wrap never ticks
        if (clear) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/multi_cnt_led.sv
// Multi-mode LED driver: toggle / one-hot shift / binary count / hold, stepped by a prescaler.
// LEDs update on the same edge that raises tick; a mode change restarts the period.
module multi_cnt_led
    import cnt_pkg::*;
#(
    parameter int               CNT_W   = 25,
    parameter logic [CNT_W-1:0] CNT_VAL = 25'd25_000_000,
    parameter int               CH_NUM  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    multi_cnt_led_if.slave   bus
);

    localparam logic [CH_NUM-1:0] ONE_HOT0 = {{(CH_NUM-1){1'b0}}, 1'b1};

    mode_e             mode_q, mode_d;
    logic              mode_chg;
    logic [CH_NUM-1:0] led_q, led_d;
    logic              wrap;
    logic              tick;

    cnt_tick #(
        .CNT_W   (CNT_W),
        .CNT_VAL (CNT_VAL)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .clear (mode_chg),
        .wrap  (wrap),
        .tick  (tick)
    );

    always_comb begin
        mode_d   = bus.mode;
        mode_chg = (bus.mode != mode_q);
        led_d    = led_q;
        if (mode_chg) begin
            // load the start pattern of the incoming mode
            case (bus.mode)
                MODE_TOGGLE: led_d = '0;
                MODE_SHIFT:  led_d = ONE_HOT0;
                MODE_BINARY: led_d = '0;
                default:     led_d = led_q;
            endcase
        end else if (wrap) begin
            case (mode_q)
                MODE_TOGGLE: led_d = ~led_q;
                MODE_SHIFT:  led_d = {led_q[CH_NUM-2:0], led_q[CH_NUM-1]};
                MODE_BINARY: led_d = led_q + 1'b1;
                default:     led_d = led_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_TOGGLE;
            led_q  <= '0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick;

endmodule

// File: doc/multi_cnt_led.md
MULTI_CNT_LED -- requirements
Module: multi_cnt_led

Interface
REQ-001 Parameter CNT_W, default 25, width of prescaler counter.
REQ-002 Parameter CNT_VAL, default 25'd25_000_000, prescaler period in clk cycles (legal range 2 .. 2^CNT_W-1).
REQ-003 Parameter CH_NUM, default 4, number of LED channels (legal range 2..16).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  count enable; low freezes prescaler and LEDs.
REQ-007 mode  input  2  display mode: 00 TOGGLE, 01 SHIFT, 10 BINARY, 11 HOLD.
REQ-008 tick  output  1  one-cycle pulse at each prescaler wrap.
REQ-009 led  output  CH_NUM  LED drive vector, registered.

Function
REQ-010 Prescaler cnt SHALL count 0 .. CNT_VAL-1 when en=1 and wrap to 0; hold value when en=0.
REQ-011 tick SHALL be registered and assert for exactly one cycle, in the cycle after cnt == CNT_VAL-1 with en=1, giving tick period CNT_VAL cycles.
REQ-012 mode SHALL be registered into mode_q every cycle; mode_chg = (mode != mode_q).
REQ-013 On mode_chg (regardless of en): cnt <= 0, tick <= 0, led <= initial pattern of new mode: TOGGLE all-0, SHIFT {0..0,1}, BINARY 0, HOLD unchanged.
REQ-014 mode_chg SHALL take priority over prescaler wrap occurring in the same cycle; that wrap is discarded.
REQ-015 TOGGLE: on each wrap, led <= ~led (all channels together).
REQ-016 SHIFT: on each wrap, led rotates left by one (led[CH_NUM-1] wraps to led[0]); exactly one bit set at all times outside reset.
REQ-017 BINARY: on each wrap, led <= led + 1 modulo 2^CH_NUM (all-ones wraps to 0).
REQ-018 HOLD: led SHALL not change; prescaler and tick continue per REQ-010/011.
REQ-019 If SHIFT is entered while led is not one-hot (not reachable by design) led SHALL still be forced to {0..0,1} by REQ-013.
REQ-020 en deassert mid-period SHALL resume counting from the held cnt value, no tick lost or duplicated.
REQ-021 led update and tick SHALL occur in the same clk edge (wrap edge + 1 registered stage, consistent across modes).

Reset
REQ-022 rst_n low SHALL asynchronously set cnt=0, tick=0, led=0, mode_q=00 (TOGGLE).
REQ-023 After release with mode!=00, first edge detects mode_chg and applies REQ-013.
REQ-024 Reset asserted mid-period SHALL discard partial count; no tick emitted until CNT_VAL full cycles after release.

Structure
REQ-025 Mode encodings (MODE_TOGGLE, MODE_SHIFT, MODE_BINARY, MODE_HOLD) SHALL live in shared package cnt_pkg.
REQ-026 Prescaler (cnt, wrap, tick, clear, en) SHALL be sub-module cnt_tick, parametrised by CNT_W and CNT_VAL, reusable by other blocks.
REQ-027 Top multi_cnt_led holds mode register, change detect and LED pattern logic only.

Verification (clk 20 ns, CNT_VAL=10, CH_NUM=4)
REQ-028 rst_n low 50 ns, mode=00, en=1 -> tick every 200 ns; led 0000->1111->0000 per tick.
REQ-029 mode=01 from reset -> led=0001 after first edge, then 0010,0100,1000,0001 on successive ticks.
REQ-030 mode=10 -> led counts 0000..1111 then 0000, one step per 10 cycles.
REQ-031 en low for 7 cycles at cnt=4 -> cnt holds 4, next tick delayed by exactly 7 cycles.
REQ-032 Switch mode 00->01 in same cycle as cnt==9 -> no tick, cnt=0, led=0001, next tick 10 cycles later.
REQ-033 rst_n pulsed low 550 ns mid-operation -> led=0000, tick=0 immediately (asynchronous); first tick 10 cycles after release.
